// File: rtl/reg_xfer_seq_8088.sv
// reg_xfer_seq_8088: register-transfer sequencer driving the 8088 register bank.
// Revision: 1.0 - initial release.
`default_nettype none

module reg_xfer_seq_8088 #(
  parameter logic [3:0] LAST_REG = 4'hD,
  parameter logic [3:0] GP_LAST  = 4'h3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_dst,
  input  logic [3:0]  cmd_src,
  input  logic        cmd_size,
  input  logic        cmd_dst_hi,
  input  logic        cmd_src_hi,
  input  logic [15:0] cmd_imm,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        rb_en_write,
  output logic [3:0]  rb_reg_write,
  output logic [15:0] rb_write_data,
  output logic        rb_size,
  output logic        rb_select_high_low,
  output logic [3:0]  rb_reg_read1,
  output logic [3:0]  rb_reg_read2,
  input  logic [15:0] rb_read_data1,
  input  logic [15:0] rb_read_data2
);

  localparam logic [1:0] OP_MOV  = 2'd0;
  localparam logic [1:0] OP_XCHG = 2'd1;
  localparam logic [1:0] OP_LDI  = 2'd2;
  localparam logic [1:0] OP_INC  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_WR_DST = 3'd2,
    S_WR_SRC = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [1:0]  op_q;
  logic [3:0]  dst_q, src_q;
  logic        size_q, dst_hi_q, src_hi_q, err_q;
  logic [15:0] imm_q, word1_q, word2_q;

  logic        two_op, illegal;
  logic [7:0]  byte1, byte2, inc_byte;
  logic [15:0] src_val, dst_val, inc_val, ldi_val;

  // MOV and XCHG are the only ops that read a source register.
  assign two_op  = (cmd_op == OP_MOV) || (cmd_op == OP_XCHG);
  assign illegal = (cmd_dst > LAST_REG) || (two_op && (cmd_src > LAST_REG)) ||
                   (!cmd_size && (cmd_dst > GP_LAST)) ||
                   (!cmd_size && two_op && (cmd_src > GP_LAST));

  // word1 holds src (MOV/XCHG) or dst (INC); word2 holds dst for XCHG.
  assign byte1    = (op_q == OP_INC ? dst_hi_q : src_hi_q) ? word1_q[15:8] : word1_q[7:0];
  assign byte2    = dst_hi_q ? word2_q[15:8] : word2_q[7:0];
  assign inc_byte = byte1 + 8'd1;
  assign src_val  = size_q ? word1_q : {8'h00, byte1};
  assign dst_val  = size_q ? word2_q : {8'h00, byte2};
  assign inc_val  = size_q ? (word1_q + 16'd1) : {8'h00, inc_byte};
  assign ldi_val  = size_q ? imm_q : {8'h00, imm_q[7:0]};

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      op_q     <= 2'd0;
      dst_q    <= 4'd0;
      src_q    <= 4'd0;
      size_q   <= 1'b0;
      dst_hi_q <= 1'b0;
      src_hi_q <= 1'b0;
      imm_q    <= 16'd0;
      err_q    <= 1'b0;
      word1_q  <= 16'd0;
      word2_q  <= 16'd0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && cmd_valid) begin
        op_q     <= cmd_op;
        dst_q    <= cmd_dst;
        src_q    <= cmd_src;
        size_q   <= cmd_size;
        dst_hi_q <= cmd_dst_hi;
        src_hi_q <= cmd_src_hi;
        imm_q    <= cmd_imm;
        err_q    <= illegal;
      end
      if (state == S_READ) begin
        word1_q <= rb_read_data1;
        word2_q <= rb_read_data2;
      end
    end
  end

  always_comb begin
    state_next         = state;
    cmd_ready          = 1'b0;
    done               = 1'b0;
    err                = 1'b0;
    rb_en_write        = 1'b0;
    rb_reg_write       = 4'd0;
    rb_write_data      = 16'd0;
    rb_size            = 1'b0;
    rb_select_high_low = 1'b0;
    rb_reg_read1       = 4'd0;
    rb_reg_read2       = 4'd0;
    case (state)
      S_IDLE: begin
        cmd_ready = !reset;
        if (cmd_valid) begin
          if (illegal)               state_next = S_DONE;
          else if (cmd_op == OP_LDI) state_next = S_WR_DST;
          else                       state_next = S_READ;
        end
      end
      S_READ: begin
        rb_reg_read1 = (op_q == OP_INC) ? dst_q : src_q;
        rb_reg_read2 = (op_q == OP_INC) ? 4'd0 : dst_q;
        state_next   = S_WR_DST;
      end
      S_WR_DST: begin
        rb_en_write        = 1'b1;
        rb_reg_write       = dst_q;
        rb_size            = size_q;
        rb_select_high_low = !size_q && dst_hi_q;
        case (op_q)
          OP_LDI:  rb_write_data = ldi_val;
          OP_INC:  rb_write_data = inc_val;
          default: rb_write_data = src_val;
        endcase
        state_next = (op_q == OP_XCHG) ? S_WR_SRC : S_DONE;
      end
      S_WR_SRC: begin
        rb_en_write        = 1'b1;
        rb_reg_write       = src_q;
        rb_size            = size_q;
        rb_select_high_low = !size_q && src_hi_q;
        rb_write_data      = dst_val;
        state_next         = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        err        = err_q;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_xfer_seq_8088.sv
// tb_reg_xfer_seq_8088: directed vector table, reset-abort sequence and random commands
// against an arithmetic model of the register bank.
`default_nettype none

module tb_reg_xfer_seq_8088;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_dst, cmd_src;
  logic        cmd_size, cmd_dst_hi, cmd_src_hi;
  logic [15:0] cmd_imm;
  logic        busy, done, err;
  logic        rb_en_write, rb_size, rb_select_high_low;
  logic [3:0]  rb_reg_write, rb_reg_read1, rb_reg_read2;
  logic [15:0] rb_write_data, rb_read_data1, rb_read_data2;

  logic [15:0] bank [16];
  logic [15:0] ref_bank [16];
  logic        pre_we;
  logic [3:0]  pre_addr;
  logic [15:0] pre_data;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  reg_xfer_seq_8088 dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_size(cmd_size),
    .cmd_dst_hi(cmd_dst_hi), .cmd_src_hi(cmd_src_hi), .cmd_imm(cmd_imm),
    .busy(busy), .done(done), .err(err), .rb_en_write(rb_en_write),
    .rb_reg_write(rb_reg_write), .rb_write_data(rb_write_data), .rb_size(rb_size),
    .rb_select_high_low(rb_select_high_low), .rb_reg_read1(rb_reg_read1),
    .rb_reg_read2(rb_reg_read2), .rb_read_data1(rb_read_data1), .rb_read_data2(rb_read_data2)
  );

  // Register bank: combinational reads, byte-or-word writes.
  assign rb_read_data1 = bank[rb_reg_read1];
  assign rb_read_data2 = bank[rb_reg_read2];
  always @(posedge clk) begin
    if (pre_we) bank[pre_addr] <= pre_data;
    else if (rb_en_write) begin
      if (rb_size)                 bank[rb_reg_write]       <= rb_write_data;
      else if (rb_select_high_low) bank[rb_reg_write][15:8] <= rb_write_data[7:0];
      else                         bank[rb_reg_write][7:0]  <= rb_write_data[7:0];
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int ref_get(input logic [3:0] r, input logic sz, input logic hi);
    int w = ref_bank[r];
    if (sz) return w;
    return hi ? w / 256 : w % 256;
  endfunction

  task automatic ref_put(input logic [3:0] r, input logic sz, input logic hi, input int v);
    int w = ref_bank[r];
    if (sz)      ref_bank[r] = 16'(v);
    else if (hi) ref_bank[r] = 16'((w % 256) + (v % 256) * 256);
    else         ref_bank[r] = 16'((w / 256) * 256 + (v % 256));
  endtask

  // Semantic model: legality rules, then values written, then bank update.
  task automatic model(input logic [1:0] op, input logic [3:0] dst, input logic [3:0] src,
                       input logic sz, input logic dhi, input logic shi, input logic [15:0] imm,
                       output logic e, output logic [15:0] w1, output logic [15:0] w2);
    int  sv, dv;
    bit  two;
    two = (op == 2'd0) || (op == 2'd1);
    e   = (dst > 13) || (two && src > 13) || (!sz && dst > 3) || (!sz && two && src > 3);
    w1  = 16'd0;
    w2  = 16'd0;
    if (e) return;
    sv = two ? ref_get(src, sz, shi) : 0;
    dv = ref_get(dst, sz, dhi);
    case (op)
      2'd0: w1 = 16'(sv);
      2'd1: begin w1 = 16'(sv); w2 = 16'(dv); end
      2'd2: w1 = sz ? imm : 16'(int'(imm) % 256);
      default: w1 = sz ? 16'((dv + 1) % 65536) : 16'((dv + 1) % 256);
    endcase
    ref_put(dst, sz, dhi, int'(w1));
    if (op == 2'd1) ref_put(src, sz, shi, int'(w2));
  endtask

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
    ref_bank[a] = d;
  endtask

  task automatic drive(input logic [1:0] op, input logic [3:0] dst, input logic [3:0] src,
                       input logic sz, input logic dhi, input logic shi, input logic [15:0] imm);
    cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src = src;
    cmd_size = sz; cmd_dst_hi = dhi; cmd_src_hi = shi; cmd_imm = imm;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [3:0] dst, input logic [3:0] src,
                         input logic sz, input logic dhi, input logic shi, input logic [15:0] imm,
                         input logic e, input logic [15:0] w1, input logic [15:0] w2);
    int   lat, t1;
    logic xchg, first, second;
    xchg = (op == 2'd1);
    t1   = (op == 2'd2) ? 1 : 2;
    lat  = e ? 1 : (op == 2'd2 ? 2 : (xchg ? 4 : 3));
    @(negedge clk);
    chk("ready_idle", 16'(cmd_ready), 16'd1);
    chk("done_idle", 16'(done), 16'd0);
    drive(op, dst, src, sz, dhi, shi, imm);
    @(posedge clk);
    #1;
    // Garbage while busy must be ignored.
    drive(2'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), 16'($urandom));
    cmd_valid = 1'($urandom);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      first  = !e && (k == t1);
      second = !e && xchg && (k == t1 + 1);
      chk("busy", 16'(busy), 16'd1);
      chk("ready_busy", 16'(cmd_ready), 16'd0);
      chk("wr_en", 16'(rb_en_write), 16'(first || second));
      chk("done", 16'(done), 16'(k == lat));
      if (k == lat) chk("err", 16'(err), 16'(e));
      if (rb_en_write && (first || second)) begin
        chk("wr_reg", 16'(rb_reg_write), 16'(first ? dst : src));
        chk("wr_data", rb_write_data, first ? w1 : w2);
        chk("wr_size", 16'(rb_size), 16'(sz));
        chk("wr_sel", 16'(rb_select_high_low), 16'(sz ? 1'b0 : (first ? dhi : shi)));
      end
      if (k == lat) cmd_valid = 1'b0;
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  dst, src;
    logic        sz, dhi, shi;
    logic [15:0] imm;
    logic        pd_en; logic [15:0] pd;
    logic        ps_en; logic [15:0] ps;
    logic        e;     logic [15:0] w1, w2;
    logic        cf;    logic [15:0] fin;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        e;
    logic [15:0] w1, w2;
    logic [1:0]  op;
    logic [3:0]  dst, src;
    logic        sz, dhi, shi;
    logic [15:0] imm;

    //          op    dst   src   sz    dhi   shi   imm       pd_en pd        ps_en ps        e     w1        w2        cf    fin
    tbl[0]  = '{2'd2, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h1234, 16'h0000, 1'b1, 16'h1234};
    tbl[1]  = '{2'd0, 4'h2, 4'h1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h5555, 1'b1, 16'hAB00, 1'b0, 16'h00AB, 16'h0000, 1'b1, 16'h55AB};
    tbl[2]  = '{2'd1, 4'h3, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222, 1'b1, 16'h1111, 1'b0, 16'h1111, 16'h2222, 1'b1, 16'h1111};
    tbl[3]  = '{2'd1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h12AB, 1'b1, 16'h12AB, 1'b0, 16'h00AB, 16'h0012, 1'b1, 16'hAB12};
    tbl[4]  = '{2'd3, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h55FF, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h5500};
    tbl[5]  = '{2'd3, 4'h5, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000};
    tbl[6]  = '{2'd0, 4'hE, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    tbl[7]  = '{2'd0, 4'h4, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    tbl[8]  = '{2'd2, 4'h1, 4'h0, 1'b0, 1'b1, 1'b0, 16'h9A77, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0, 16'h0077, 16'h0000, 1'b1, 16'h7734};
    tbl[9]  = '{2'd0, 4'h7, 4'hD, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 16'hBEEF, 16'h0000, 1'b1, 16'hBEEF};
    tbl[10] = '{2'd1, 4'h6, 4'h6, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4242, 1'b1, 16'h4242, 1'b0, 16'h4242, 16'h4242, 1'b1, 16'h4242};
    tbl[11] = '{2'd0, 4'h1, 4'hF, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    tbl[12] = '{2'd3, 4'hD, 4'hF, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h00FF, 1'b0, 16'h0000, 1'b0, 16'h0100, 16'h0000, 1'b1, 16'h0100};
    tbl[13] = '{2'd1, 4'h1, 4'h2, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h3344, 1'b1, 16'h5566, 1'b0, 16'h0066, 16'h0033, 1'b1, 16'h6644};
    tbl[14] = '{2'd1, 4'h0, 4'h5, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000};

    reset = 1'b1; pre_we = 1'b0; pre_addr = 4'd0; pre_data = 16'd0;
    drive(2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    cmd_valid = 1'b0;
    for (int i = 0; i < 16; i++) preload(4'(i), 16'($urandom));
    chk("ready_in_reset", 16'(cmd_ready), 16'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 16'(cmd_ready), 16'd1);
    chk("rst_outs", {busy, done, err, rb_en_write, rb_size, rb_select_high_low, rb_reg_write,
                     rb_reg_read1, rb_reg_read2[1:0]}, 16'd0);
    chk("rst_wdata", rb_write_data, 16'd0);

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].pd_en) preload(tbl[i].dst, tbl[i].pd);
      if (tbl[i].ps_en) preload(tbl[i].src, tbl[i].ps);
      model(tbl[i].op, tbl[i].dst, tbl[i].src, tbl[i].sz, tbl[i].dhi, tbl[i].shi, tbl[i].imm,
            e, w1, w2);
      run_cmd(tbl[i].op, tbl[i].dst, tbl[i].src, tbl[i].sz, tbl[i].dhi, tbl[i].shi, tbl[i].imm,
              tbl[i].e, tbl[i].w1, tbl[i].w2);
      if (tbl[i].cf) chk("tbl_final", bank[tbl[i].dst], tbl[i].fin);
    end

    // Reset during the WR_DST cycle of an XCHG aborts the second write and the done.
    preload(4'h8, 16'hAAAA);
    preload(4'h9, 16'h5555);
    @(negedge clk);
    drive(2'd1, 4'h8, 4'h9, 1'b1, 1'b0, 1'b0, 16'd0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_read_wen", 16'(rb_en_write), 16'd0);
    @(negedge clk);
    chk("abort_wrdst_wen", 16'(rb_en_write), 16'd1);
    chk("abort_wrdst_data", rb_write_data, 16'h5555);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_wen", 16'(rb_en_write), 16'd0);
    chk("abort_done", 16'(done), 16'd0);
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_ready_rst", 16'(cmd_ready), 16'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", 16'(cmd_ready), 16'd1);
    chk("abort_done2", 16'(done), 16'd0);
    chk("abort_bank8", bank[8], 16'h5555);
    chk("abort_bank9", bank[9], 16'h5555);
    ref_bank[8] = 16'h5555;
    model(2'd2, 4'h9, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0F0F, e, w1, w2);
    run_cmd(2'd2, 4'h9, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0F0F, e, w1, w2);

    for (int n = 0; n < 200; n++) begin
      op  = 2'($urandom_range(0, 3));
      sz  = 1'($urandom);
      dhi = 1'($urandom);
      shi = 1'($urandom);
      imm = 16'($urandom);
      if ($urandom_range(0, 9) < 8) begin
        dst = 4'($urandom_range(0, sz ? 13 : 3));
        src = 4'($urandom_range(0, sz ? 13 : 3));
      end else begin
        dst = 4'($urandom_range(0, 15));
        src = 4'($urandom_range(0, 15));
      end
      model(op, dst, src, sz, dhi, shi, imm, e, w1, w2);
      run_cmd(op, dst, src, sz, dhi, shi, imm, e, w1, w2);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    for (int r = 0; r < 16; r++) chk($sformatf("bank_%0d", r), bank[r], ref_bank[r]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_xfer_seq_8088.md
# reg_xfer_seq_8088

Register-transfer sequencer for the 8088 datapath. It accepts one register-level command at a time (MOV, XCHG, load-immediate, INC) over a valid/ready handshake. It drives the read and write ports of the 8088 register bank through a fixed multi-cycle read-then-write sequence, and raises a one-cycle completion pulse. It sits between the instruction decode/control unit and the register bank, and is the only initiator on the bank's port set.

## Interface
- LAST_REG, 4'hD, highest legal register code (AX=0 … ES=D)
- GP_LAST, 4'h3, highest code allowed for 8-bit access (AX, BX, CX, DX)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer idle, command accepted when cmd_valid&&cmd_ready
- cmd_op  in  2  00 MOV dst<=src, 01 XCHG dst<->src, 10 LDI dst<=imm, 11 INC dst<=dst+1
- cmd_dst  in  4  destination register code
- cmd_src  in  4  source register code (ignored for LDI/INC)
- cmd_size  in  1  0: 8-bit, 1: 16-bit
- cmd_dst_hi  in  1  8-bit only: 1 = high byte of dst
- cmd_src_hi  in  1  8-bit only: 1 = high byte of src
- cmd_imm  in  16  immediate for LDI (8-bit uses [7:0])
- busy  out  1  command in progress (state != IDLE)
- done  out  1  one-cycle pulse at end of every accepted command
- err  out  1  valid only with done; 1 = illegal command, no write performed
- rb_en_write  out  1  bank write enable
- rb_reg_write  out  4  bank write address
- rb_write_data  out  16  bank write data
- rb_size  out  1  bank write size
- rb_select_high_low  out  1  bank byte select
- rb_reg_read1  out  4  bank read address 1
- rb_reg_read2  out  4  bank read address 2
- rb_read_data1  in  16  bank read data 1, combinational from rb_reg_read1
- rb_read_data2  in  16  bank read data 2, combinational from rb_reg_read2

## Operation
- Command fields are latched on acceptance. Inputs are ignored while busy.
- FSM states: IDLE, READ, WR_DST, WR_SRC, DONE.
- IDLE: cmd_ready=1. On accept:
  - illegal command -> DONE with err latched 1;
  - LDI -> WR_DST;
  - otherwise -> READ.
- Illegal command means any of:
  - dst > LAST_REG;
  - src > LAST_REG for MOV/XCHG;
  - 8-bit with dst > GP_LAST;
  - 8-bit MOV/XCHG with src > GP_LAST.
- READ: drive rb_reg_read1 and rb_reg_read2, then capture both data words at the clock edge.
  - MOV/XCHG: read1=src, read2=dst.
  - INC: read1=dst.
  - Next state is WR_DST.
- Byte extraction (8-bit): value = hi ? word[15:8] : word[7:0], placed on rb_write_data[7:0] with [15:8]=0.
- WR_DST: rb_en_write=1, rb_reg_write=dst, rb_size=cmd_size, rb_select_high_low=dst_hi (0 when 16-bit). Data by op:
  - MOV/XCHG: src value;
  - LDI: imm;
  - INC: dst value+1, wrapping modulo 2^16 or 2^8 by size; 8-bit wrap stays within the byte.
  - Next state is WR_SRC for XCHG, DONE otherwise.
- WR_SRC (XCHG only): rb_en_write=1, rb_reg_write=src, rb_select_high_low=src_hi, data = captured dst value. Next state is DONE.
- DONE: done=1, err=latched error. Next state is IDLE.
- Both XCHG operands are captured before either write, so XCHG AH,AL and XCHG X,X are correct. XCHG X,X writes twice with no net change.
- The block does not touch the FLAGS register for INC. Flag update belongs to the ALU path.

## Timing
- Reset (sync): state returns to IDLE, all latched fields and err are cleared, and rb_* outputs, busy and done go to 0.
- cmd_ready is gated by !reset. In the cycle after the reset edge, cmd_ready=1 and every other output is 0.
- All outputs decode from registered state and latched fields. They carry no combinational path from cmd_*.
- Latency, counting accept edge as N:
  - MOV/INC: READ N+1, WR_DST N+2, done N+3;
  - XCHG: READ N+1, writes N+2 and N+3, done N+4;
  - LDI: WR_DST N+1, done N+2;
  - illegal: done+err N+1.
- Back-to-back: cmd_ready is 1 in the cycle after DONE, so the minimum command spacing is the latency +1.
- Reset asserted in any state aborts the command. No write is issued in the cycle after the reset edge, and no done is produced for the aborted command.
- rb_en_write is high only in WR_DST and WR_SRC, for exactly one cycle each.

## Test plan
- Reset then LDI dst=0 size=1 imm=16'h1234 -> write AX=1234 at N+1, done at N+2, err=0, cmd_ready=1 at N+3.
- MOV 8-bit src=1 hi=1 (BX=16'hAB00), dst=2 lo -> write rb_reg_write=2, select=0, data=16'h00AB at N+2, done at N+3.
- XCHG 16-bit AX=16'h1111, DX=16'h2222 -> DX<=1111 at N+2, AX<=2222 at N+3, done N+4. Repeat with XCHG AH,AL on AX=16'h12AB -> result 16'hAB12.
- INC 8-bit dst=3 hi=0, DL=8'hFF, DH=8'h55 -> data 16'h0000 with select=0, so DH is unchanged. INC 16-bit on 16'hFFFF -> 16'h0000.
- Illegal: MOV dst=4'hE, and 8-bit MOV dst=4 (SP) -> no rb_en_write, done+err at N+1.
- Reset in the WR_DST cycle of an XCHG -> no WR_SRC write, no done, idle outputs next cycle. A new command is then accepted normally.
